// File: rtl/soc_system_switches_debounce_if.sv
// Switch-conditioning bus: raw pins in, debounced vector, change pulses and edge/irq status out.
interface soc_system_switches_debounce_if #(
  parameter int unsigned WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_debounced;
  logic [WIDTH-1:0] sw_changed;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] irq_mask;
  logic             irq;

  // Board/PIO side: drives the pins and the edge-capture controls.
  modport master (
    output sw_raw,
    output edge_clear,
    output irq_mask,
    input  sw_debounced,
    input  sw_changed,
    input  edge_capture,
    input  irq
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    input  edge_clear,
    input  irq_mask,
    output sw_debounced,
    output sw_changed,
    output edge_capture,
    output irq
  );
endinterface

// File: rtl/soc_system_switches_debounce.sv
// Slide-switch conditioner: two-flop synchronizer and per-bit stability-counter
// debounce in front of the switches PIO in_port. sw_debounced feeds in_port.
// Optional sticky rising-edge capture and interrupt: SWITCHES_DEBOUNCE_EDGE_IRQ_EN.
module soc_system_switches_debounce #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  soc_system_switches_debounce_if.slave bus
);

  // Terminal count: the mismatch that reaches it is the DEBOUNCE_CYCLES-th in a row.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [WIDTH-1:0]     stable;
  logic [WIDTH-1:0]     changed;
  logic [CNT_WIDTH-1:0] cnt      [WIDTH];
  logic [WIDTH-1:0]     stable_next;
  logic [WIDTH-1:0]     changed_next;
  logic [CNT_WIDTH-1:0] cnt_next [WIDTH];

  // Two-flop synchronizer bringing the asynchronous pins into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce decision: any agreeing sample restarts the count; the
  // last mismatch in a full run flips the stable value and raises a pulse.
  always_comb begin
    stable_next  = stable;
    changed_next = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i]  = sync2[i];
          changed_next[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Debounce state: counters, stable vector and one-cycle change pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable  <= '0;
      changed <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable  <= stable_next;
      changed <= changed_next;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign bus.sw_debounced = stable;
  assign bus.sw_changed   = changed;

`ifdef SWITCHES_DEBOUNCE_EDGE_IRQ_EN
  logic [WIDTH-1:0] capture;
  logic             irq_q;

  // Sticky rising-edge flags (a new set beats a simultaneous clear) and the masked interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture <= '0;
      irq_q   <= 1'b0;
    end else begin
      capture <= (capture & ~bus.edge_clear) | (changed & stable);
      irq_q   <= |(capture & bus.irq_mask);
    end
  end

  assign bus.edge_capture = capture;
  assign bus.irq          = irq_q;
`else
  // Edge capture not built: status tied off, controls intentionally ignored.
  logic unused_edge_inputs;
  assign unused_edge_inputs = ^{bus.edge_clear, bus.irq_mask};
  assign bus.edge_capture   = '0;
  assign bus.irq            = 1'b0;
`endif

endmodule

// File: tb/tb_soc_system_switches_debounce.sv
// Bench for soc_system_switches_debounce: D=4 and D=1 instances, directed
// scenarios plus randomized pins against a sliding-window reference model.
module tb_soc_system_switches_debounce;

  localparam int unsigned W = 10;

`ifdef SWITCHES_DEBOUNCE_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // Reference state: raw samples newest-first (hist[0] = last edge's sample),
  // stable values, pulses and edge/irq status as the DUT should show them.
  logic [W-1:0] hist [0:7];
  logic [W-1:0] m_st4, m_ch4, m_st1, m_ch1, m_ec;
  logic         m_irq;

  soc_system_switches_debounce_if #(.WIDTH(W)) bus4 ();
  soc_system_switches_debounce_if #(.WIDTH(W)) bus1 ();

  soc_system_switches_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  soc_system_switches_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int j = 0; j < 8; j++) hist[j] = '0;
    m_st4 = '0; m_ch4 = '0; m_st1 = '0; m_ch1 = '0; m_ec = '0; m_irq = 1'b0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
  // A bit flips when the last D synchronized samples (2 edges old) all disagree with it.
  task automatic tick(input logic [W-1:0] raw, input logic [W-1:0] clr, input logic [W-1:0] mask);
    logic [W-1:0] f4, f1, ec_n;
    logic         irq_n;
    bus4.sw_raw = raw; bus4.edge_clear = clr; bus4.irq_mask = mask;
    bus1.sw_raw = raw;
    @(posedge clk);
    f4 = '1;
    for (int j = 1; j <= 4; j++) f4 &= hist[j] ^ m_st4;
    f1    = hist[1] ^ m_st1;
    ec_n  = (m_ec & ~clr) | (m_ch4 & m_st4);
    irq_n = |(m_ec & mask);
    m_ec  = EDGE_EN ? ec_n : '0;
    m_irq = EDGE_EN ? irq_n : 1'b0;
    m_ch4 = f4; m_st4 = m_st4 ^ f4;
    m_ch1 = f1; m_st1 = m_st1 ^ f1;
    for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = raw;
    #1;
  endtask

  task automatic apply_reset(input logic [W-1:0] raw);
    bus4.sw_raw = raw; bus1.sw_raw = raw;
    bus4.edge_clear = '0; bus4.irq_mask = '0;
    #2 reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    // Power-up: reset held from time zero.
    total++; if (bus4.sw_debounced !== '0) begin bad++; $display("FAIL por_deb got=%h want=%h", bus4.sw_debounced, 10'h000); end
    total++; if (bus4.sw_changed !== '0) begin bad++; $display("FAIL por_chg got=%h want=%h", bus4.sw_changed, 10'h000); end
    total++; if (bus4.edge_capture !== '0) begin bad++; $display("FAIL por_ec got=%h want=%h", bus4.edge_capture, 10'h000); end
    total++; if (bus4.irq !== 1'b0) begin bad++; $display("FAIL por_irq got=%b want=0", bus4.irq); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    // Mid-count reset: D=1 copy has already flipped, D=4 copy is partway.
    for (int k = 0; k < 3; k++) tick(10'h001, '0, '0);
    total++; if (bus1.sw_debounced !== 10'h001) begin bad++; $display("FAIL pre_rst_deb1 got=%h want=%h", bus1.sw_debounced, 10'h001); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus4.sw_debounced !== '0) begin bad++; $display("FAIL rst_async_deb got=%h want=%h", bus4.sw_debounced, 10'h000); end
    total++; if (bus1.sw_debounced !== '0) begin bad++; $display("FAIL rst_async_deb1 got=%h want=%h", bus1.sw_debounced, 10'h000); end
    total++; if (bus1.sw_changed !== '0) begin bad++; $display("FAIL rst_async_chg1 got=%h want=%h", bus1.sw_changed, 10'h000); end
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(10'h001, '0, '0);
      total++;
      if (bus4.sw_debounced !== ((k >= 6) ? 10'h001 : 10'h000)) begin
        bad++; $display("FAIL rst_restart_k%0d got=%h want=%h", k, bus4.sw_debounced, (k >= 6) ? 10'h001 : 10'h000);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [W-1:0] exp_d, exp_c;
    apply_reset('0);
    for (int k = 1; k <= 7; k++) begin
      tick(10'h001, '0, '0);
      exp_d = (k >= 6) ? 10'h001 : 10'h000;
      exp_c = (k == 6) ? 10'h001 : 10'h000;
      total++; if (bus4.sw_debounced !== exp_d) begin bad++; $display("FAIL step_deb_k%0d got=%h want=%h", k, bus4.sw_debounced, exp_d); end
      total++; if (bus4.sw_changed !== exp_c) begin bad++; $display("FAIL step_chg_k%0d got=%h want=%h", k, bus4.sw_changed, exp_c); end
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] pat [4];
    logic [W-1:0] exp_d, exp_c;
    pat[0] = 10'h008; pat[1] = 10'h008; pat[2] = 10'h008; pat[3] = 10'h000;
    apply_reset('0);
    for (int k = 0; k < 4; k++) begin
      tick(pat[k], '0, '0);
      total++; if (bus4.sw_debounced !== '0) begin bad++; $display("FAIL bounce_hold_k%0d got=%h want=%h", k, bus4.sw_debounced, 10'h000); end
    end
    for (int k = 1; k <= 7; k++) begin
      tick(10'h008, '0, '0);
      exp_d = (k >= 6) ? 10'h008 : 10'h000;
      exp_c = (k == 6) ? 10'h008 : 10'h000;
      total++; if (bus4.sw_debounced !== exp_d) begin bad++; $display("FAIL bounce_deb_k%0d got=%h want=%h", k, bus4.sw_debounced, exp_d); end
      total++; if (bus4.sw_changed !== exp_c) begin bad++; $display("FAIL bounce_chg_k%0d got=%h want=%h", k, bus4.sw_changed, exp_c); end
    end
  endtask

  task automatic test_all_bits();
    logic [W-1:0] exp_d, exp_c;
    apply_reset('0);
    for (int k = 1; k <= 7; k++) begin
      tick(10'h3FF, '0, '0);
      exp_d = (k >= 6) ? 10'h3FF : 10'h000;
      exp_c = (k == 6) ? 10'h3FF : 10'h000;
      total++; if (bus4.sw_debounced !== exp_d) begin bad++; $display("FAIL all_up_deb_k%0d got=%h want=%h", k, bus4.sw_debounced, exp_d); end
      total++; if (bus4.sw_changed !== exp_c) begin bad++; $display("FAIL all_up_chg_k%0d got=%h want=%h", k, bus4.sw_changed, exp_c); end
    end
    for (int k = 1; k <= 7; k++) begin
      tick(10'h000, '0, '0);
      exp_d = (k >= 6) ? 10'h000 : 10'h3FF;
      exp_c = (k == 6) ? 10'h3FF : 10'h000;
      total++; if (bus4.sw_debounced !== exp_d) begin bad++; $display("FAIL all_dn_deb_k%0d got=%h want=%h", k, bus4.sw_debounced, exp_d); end
      total++; if (bus4.sw_changed !== exp_c) begin bad++; $display("FAIL all_dn_chg_k%0d got=%h want=%h", k, bus4.sw_changed, exp_c); end
    end
  endtask

  task automatic test_edge_irq();
    logic [W-1:0] exp_e;
    logic         exp_i;
    apply_reset('0);
    // Rise on bit 5: flip at edge 6, capture at 7, irq at 8.
    for (int k = 1; k <= 8; k++) begin
      tick(10'h020, '0, 10'h020);
      exp_e = (EDGE_EN && k >= 7) ? 10'h020 : 10'h000;
      exp_i = EDGE_EN && (k >= 8);
      total++; if (bus4.edge_capture !== exp_e) begin bad++; $display("FAIL edge_set_k%0d got=%h want=%h", k, bus4.edge_capture, exp_e); end
      total++; if (bus4.irq !== exp_i) begin bad++; $display("FAIL irq_set_k%0d got=%b want=%b", k, bus4.irq, exp_i); end
    end
    tick(10'h020, 10'h020, 10'h020);
    total++; if (bus4.edge_capture !== '0) begin bad++; $display("FAIL edge_clr got=%h want=%h", bus4.edge_capture, 10'h000); end
    tick(10'h020, '0, 10'h020);
    total++; if (bus4.irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b want=0", bus4.irq); end
    // Falling flip must not capture.
    for (int k = 1; k <= 7; k++) tick(10'h000, '0, 10'h020);
    total++; if (bus4.edge_capture !== '0) begin bad++; $display("FAIL edge_fall got=%h want=%h", bus4.edge_capture, 10'h000); end
    // New rise with a clear strobe on the capturing edge: set wins.
    for (int k = 1; k <= 6; k++) tick(10'h020, '0, 10'h020);
    tick(10'h020, 10'h020, 10'h020);
    exp_e = EDGE_EN ? 10'h020 : 10'h000;
    total++; if (bus4.edge_capture !== exp_e) begin bad++; $display("FAIL edge_set_wins got=%h want=%h", bus4.edge_capture, exp_e); end
  endtask

  task automatic test_debounce_one();
    logic [W-1:0] exp_d, exp_c;
    apply_reset('0);
    for (int k = 1; k <= 4; k++) begin
      tick(10'h2A5, '0, '0);
      exp_d = (k >= 3) ? 10'h2A5 : 10'h000;
      exp_c = (k == 3) ? 10'h2A5 : 10'h000;
      total++; if (bus1.sw_debounced !== exp_d) begin bad++; $display("FAIL d1_deb_k%0d got=%h want=%h", k, bus1.sw_debounced, exp_d); end
      total++; if (bus1.sw_changed !== exp_c) begin bad++; $display("FAIL d1_chg_k%0d got=%h want=%h", k, bus1.sw_changed, exp_c); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] cur, clr, mask;
    cur = '0;
    apply_reset('0);
    for (int n = 0; n < 800; n++) begin
      if ((n % 64) < 40 && $urandom_range(0, 4) == 0) cur = cur ^ (W'($urandom) & W'($urandom));
      clr  = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
      mask = W'($urandom);
      tick(cur, clr, mask);
      total++; if (bus4.sw_debounced !== m_st4) begin bad++; $display("FAIL rnd_deb4 n=%0d got=%h want=%h", n, bus4.sw_debounced, m_st4); end
      total++; if (bus4.sw_changed !== m_ch4) begin bad++; $display("FAIL rnd_chg4 n=%0d got=%h want=%h", n, bus4.sw_changed, m_ch4); end
      total++; if (bus4.edge_capture !== m_ec) begin bad++; $display("FAIL rnd_ec n=%0d got=%h want=%h", n, bus4.edge_capture, m_ec); end
      total++; if (bus4.irq !== m_irq) begin bad++; $display("FAIL rnd_irq n=%0d got=%b want=%b", n, bus4.irq, m_irq); end
      total++; if (bus1.sw_debounced !== m_st1) begin bad++; $display("FAIL rnd_deb1 n=%0d got=%h want=%h", n, bus1.sw_debounced, m_st1); end
      total++; if (bus1.sw_changed !== m_ch1) begin bad++; $display("FAIL rnd_chg1 n=%0d got=%h want=%h", n, bus1.sw_changed, m_ch1); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus4.sw_raw = '0; bus4.edge_clear = '0; bus4.irq_mask = '0;
    bus1.sw_raw = '0; bus1.edge_clear = '0; bus1.irq_mask = '0;
    model_clear();
    #1;
    test_reset();
    test_clean_step();
    test_bounce();
    test_all_bits();
    test_edge_irq();
    test_debounce_one();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_system_switches_debounce.md
Name: soc_system_switches_debounce

Overview:
Conditions the raw slide-switch pins before they reach the switches PIO input port.
- Synchronizes each switch bit into the clk domain.
- Debounces each bit independently with a per-bit stability counter.
- Emits the clean vector plus one-cycle change pulses.
- Sits between the top-level switch pins and the PIO's in_port; sw_debounced drives in_port directly.

Parameters:
WIDTH, 10, number of switch bits.
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronized bit must differ from its stable value before the stable value flips (1 ms at 50 MHz); legal range 1..2**CNT_WIDTH.
CNT_WIDTH, 16, width of each per-bit counter; must hold DEBOUNCE_CYCLES-1.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous active-high reset.
sw_raw  input  WIDTH  raw asynchronous switch pins.
sw_debounced  output  WIDTH  debounced stable value; feeds PIO in_port.
sw_changed  output  WIDTH  one-cycle pulse per bit when that bit's stable value flips.
edge_capture  output  WIDTH  sticky rising-edge flags (optional feature).
edge_clear  input  WIDTH  write-1-to-clear strobes for edge_capture (optional feature).
irq_mask  input  WIDTH  per-bit interrupt enable (optional feature).
irq  output  1  interrupt request (optional feature).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: sync stages 0, counters 0, sw_debounced 0, sw_changed 0, edge_capture 0, irq 0.
- Reset takes effect immediately and mid-debounce discards any partial count.
- Synchronizer: two-flop chain per bit, sw_raw -> s1 -> s2. Only s2 is used downstream.
- Per-bit debounce, evaluated every clk edge:
  - s2 == stable: counter <= 0.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0, sw_changed bit <= 1.
  - Otherwise the sw_changed bit is 0 (registered pulse, exactly one cycle wide).
- Glitch rejection: any cycle with s2 back equal to stable restarts the count from 0. A bounce shorter than DEBOUNCE_CYCLES cycles never reaches sw_debounced.
- Latency: a clean step on sw_raw appears on sw_debounced exactly DEBOUNCE_CYCLES+2 rising edges later. This is 2 edges for the synchronizer plus DEBOUNCE_CYCLES edges for the count. sw_changed pulses on the same edge that sw_debounced updates.
- DEBOUNCE_CYCLES=1: stable follows s2 on the first mismatching edge (pure synchronizer plus 1 register).
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- Counters saturate by construction (cleared on flip) and never wrap.
- Outputs are registered; no combinational path from sw_raw to any output.

Optional Feature:
Macro: SWITCHES_DEBOUNCE_EDGE_IRQ_EN.
- Defined:
  - edge_capture[i] sets on the cycle after a 0->1 flip of stable[i] (i.e. registered from sw_changed[i] & sw_debounced[i]).
  - edge_capture[i] clears when edge_clear[i]=1. If set and clear occur in the same cycle, set wins.
  - irq is registered: irq <= |(edge_capture & irq_mask). It asserts one cycle after edge_capture sets.
- Undefined:
  - edge_capture and irq are tied to 0.
  - edge_clear and irq_mask are ignored.
  - The port list is unchanged.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset asserted mid-count (sw_raw[0]=1 held 3 cycles, then reset pulse) -> all outputs 0 immediately; after release, full 6-edge latency restarts.
- sw_raw=10'h001 clean step from 0 -> sw_debounced=10'h001 exactly 6 edges later; sw_changed=10'h001 for one cycle on that edge.
- sw_raw[3] toggles 1 for 3 cycles, 0 for 1 cycle, then 1 steady -> no change during bounce; sw_debounced[3]=1 exactly 6 edges after the final rise.
- sw_raw 0 -> 10'h3FF in one cycle -> all 10 bits flip on the same edge; sw_changed=10'h3FF for one cycle. Then back to 0 -> sw_debounced=0 after 6 edges.
- With macro: bit 5 rises, irq_mask=10'h020 -> edge_capture=10'h020, then irq=1 one cycle later. edge_clear=10'h020 -> both clear. Clear on the same cycle as a new set -> edge_capture stays 1.
- DEBOUNCE_CYCLES=1 -> sw_raw step reaches sw_debounced after 3 edges.
